t05_spi_byte_engine: RTL and testbench
======================================

Name: t05_spi_byte_engine

Overview:
SPI mode-0 master byte engine, directly downstream of the SPI clock divider.
- Consumes a one-cycle half-period strobe from the divider and generates SCLK, MOSI and CS_n toward the SD card.
- Shifts one byte out MSB-first while shifting one byte in from MISO.
- Presents the result to the SD-card controller FSM with a start/valid handshake.
- The divider's freq_flag selects the strobe rate, so this block is rate-agnostic.

Parameters:
- DATA_W, 8: bits per transfer.
- CS_SETUP_TICKS, 1: half-periods between CS_n falling and the first SCLK rise (range 1..15).

Ports:
- clk, input, 1: system clock.
- nrst, input, 1: asynchronous active-low reset.
- half_tick, input, 1: one-clk strobe from the divider, once per SCLK half-period.
- start, input, 1: request a transfer; sampled only when ready=1.
- tx_byte, input, DATA_W: byte to send; latched on accepted start.
- cs_hold, input, 1: keep CS_n low after this byte; latched on accepted start.
- cs_release, input, 1: force CS_n high while idle.
- miso, input, 1: serial data from the card.
- sclk, output, 1: SPI clock, idle low.
- mosi, output, 1: serial data to the card, idle high.
- cs_n, output, 1: chip select, active low.
- rx_byte, output, DATA_W: last received byte; held until the next DONE.
- rx_valid, output, 1: one-clk pulse when rx_byte updates.
- ready, output, 1: 1 in IDLE only.

Behaviour:
- Reset (async, nrst=0), from any state including mid-transfer:
  - state=IDLE; sclk=0, mosi=1, cs_n=1, rx_byte=0, rx_valid=0, ready=1.
  - Shift registers, bit counter and setup counter cleared.
- All other updates occur on posedge clk.
- FSM states: IDLE, SETUP, LOW, HIGH, DONE.
- IDLE:
  - ready=1, sclk=0, mosi=1.
  - start=1: latch tx_byte into tx_sr, latch cs_hold, load bit counter with DATA_W, clear rx_sr, drive mosi=tx_byte[MSB].
  - If cs_n is already 0 (held from the previous byte), go to LOW; otherwise drive cs_n=0, clear the setup counter, go to SETUP.
  - start=1 together with cs_release=1: start wins and cs_release is ignored.
  - cs_release=1 without start: cs_n<=1 next clk.
- SETUP: count half_tick strobes; on the CS_SETUP_TICKS-th strobe go to LOW. sclk stays 0.
- LOW (sclk=0, mosi stable): on half_tick drive sclk<=1, shift miso into rx_sr LSB (rx_sr<={rx_sr[DATA_W-2:0],miso}), go to HIGH.
- HIGH (sclk=1): on half_tick drive sclk<=0 and decrement the bit counter.
  - Counter was 1: go to DONE.
  - Otherwise: shift tx_sr left, mosi<=new tx_sr[MSB], go to LOW.
- DONE (exactly one clk, independent of half_tick):
  - rx_byte<=rx_sr, rx_valid=1, mosi<=1, cs_n<=~cs_hold_latched.
  - Go to IDLE.
- Timing:
  - Transfer length = CS_SETUP_TICKS (skipped when CS is held) + 2*DATA_W half_ticks + 1 clk.
  - Back-to-back: a start in the first IDLE clk after DONE is accepted.
- Edge cases:
  - half_tick coinciding with the accepting start is not consumed by the new transfer.
  - half_tick is ignored in IDLE and DONE.
  - start while ready=0 is ignored (no queueing).
  - tx_byte, cs_hold and miso changes outside their sample points have no effect.
- Bit counter width is $clog2(DATA_W+1). No wrap-around: it reaches 0 only via DONE.

Optional Feature:
- Macro: T05_SPI_LOOPBACK_EN.
- When defined:
  - Extra input port loopback (1 bit) is added.
  - When loopback=1, the sampled bit is the internal mosi instead of miso, so rx_byte equals tx_byte for bench/self-test.
  - Pins behave identically otherwise.
- When undefined: no loopback port, and sampling always uses miso.

Decomposition:
- Package t05_spi_pkg holds:
  - typedef enum logic [2:0] spi_state_t {IDLE, SETUP, LOW, HIGH, DONE};
  - localparam SPI_DATA_W_DEFAULT=8;
  - localparam SPI_IDLE_MOSI=1'b1.
- No sub-module: FSM, shift registers and counters live in one module.
- Shared with the downstream SD controller via the package.

Test Plan:
- Reset mid-transfer: nrst=0 while in HIGH after 3 bits -> same clk: sclk=0, cs_n=1, mosi=1, ready=1, rx_valid=0.
- Basic byte: half_tick every 4 clks, CS_SETUP_TICKS=1, tx_byte=8'hA5, miso replays 8'h3C MSB-first -> mosi sequence 1,0,1,0,0,1,0,1 valid at each sclk rise; 8 sclk pulses; rx_valid one clk; rx_byte=8'h3C; cs_n=1 after DONE.
- CS hold chain: bytes 8'hFF then 8'h40 with cs_hold=1,1, then cs_release=1 -> cs_n stays 0 across both with no SETUP on the second byte; cs_n rises one clk after cs_release.
- Ignored start: start pulsed with tx_byte=8'h00 mid-transfer of 8'h51 -> transfer completes sending 8'h51; no second transfer.
- start and half_tick in the same clk in IDLE -> first sclk rise occurs exactly CS_SETUP_TICKS+1 half_ticks later (not CS_SETUP_TICKS); total of 16 sclk edges.
- With T05_SPI_LOOPBACK_EN defined, loopback=1, tx_byte=8'hC3, miso tied 0 -> rx_byte=8'hC3.

Source files
------------

// File: rtl/t05_spi_pkg.sv
// Shared types and constants for the SPI byte engine and its SD-card controller.
package t05_spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, DONE} spi_state_t;

  localparam int unsigned SPI_DATA_W_DEFAULT = 8;
  localparam logic        SPI_IDLE_MOSI      = 1'b1;

endpackage

// File: rtl/t05_spi_byte_engine.sv
// SPI mode-0 master byte engine driven by a divider half-period strobe.
// Optional T05_SPI_LOOPBACK_EN adds a loopback input that samples mosi instead of miso.
module t05_spi_byte_engine
  import t05_spi_pkg::*;
#(
  parameter int unsigned DATA_W         = SPI_DATA_W_DEFAULT,
  parameter int unsigned CS_SETUP_TICKS = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              half_tick,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_byte,
  input  logic              cs_hold,
  input  logic              cs_release,
  input  logic              miso,
`ifdef T05_SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic [DATA_W-1:0] rx_byte,
  output logic              rx_valid,
  output logic              ready
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  spi_state_t        state_q, state_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic [DATA_W-1:0] rx_byte_q, rx_byte_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]        setup_cnt_q, setup_cnt_d;
  logic              cs_hold_q, cs_hold_d;
  logic              sample_bit;

`ifdef T05_SPI_LOOPBACK_EN
  assign sample_bit = loopback ? mosi_q : miso;
`else
  assign sample_bit = miso;
`endif

  always_comb begin
    state_d     = state_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    bit_cnt_d   = bit_cnt_q;
    setup_cnt_d = setup_cnt_q;
    cs_hold_d   = cs_hold_q;

    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        if (start) begin
          tx_sr_d   = tx_byte;
          cs_hold_d = cs_hold;
          bit_cnt_d = CNT_W'(DATA_W);
          rx_sr_d   = '0;
          mosi_d    = tx_byte[DATA_W-1];
          if (!cs_n_q) begin
            state_d = LOW;
          end else begin
            cs_n_d      = 1'b0;
            setup_cnt_d = '0;
            state_d     = SETUP;
          end
        end else if (cs_release) begin
          cs_n_d = 1'b1;
        end
      end
      SETUP: begin
        if (half_tick) begin
          if (setup_cnt_q == 4'(CS_SETUP_TICKS - 1)) begin
            state_d = LOW;
          end else begin
            setup_cnt_d = setup_cnt_q + 4'd1;
          end
        end
      end
      LOW: begin
        if (half_tick) begin
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[DATA_W-2:0], sample_bit};
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (half_tick) begin
          sclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
          if (bit_cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end else begin
            // mosi takes the bit that becomes the new MSB after this shift
            tx_sr_d = tx_sr_q << 1;
            mosi_d  = tx_sr_q[DATA_W-2];
            state_d = LOW;
          end
        end
      end
      DONE: begin
        rx_byte_d  = rx_sr_q;
        rx_valid_d = 1'b1;
        mosi_d     = SPI_IDLE_MOSI;
        cs_n_d     = ~cs_hold_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      sclk_q      <= 1'b0;
      mosi_q      <= SPI_IDLE_MOSI;
      cs_n_q      <= 1'b1;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      setup_cnt_q <= '0;
      cs_hold_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      setup_cnt_q <= setup_cnt_d;
      cs_hold_q   <= cs_hold_d;
    end
  end

  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign ready    = (state_q == IDLE);

endmodule

// File: tb/tb_t05_spi_byte_engine.sv
// Directed self-checking bench for t05_spi_byte_engine (CS_SETUP_TICKS=1, DATA_W=8).
module tb_t05_spi_byte_engine;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       cs_hold = 1'b0;
  logic       cs_release = 1'b0;
  logic       miso = 1'b0;
  logic       loopback = 1'b0;
  logic       half_tick;
  logic       sclk, mosi, cs_n, rx_valid, ready;
  logic [7:0] rx_byte;

  logic       ht_auto = 1'b0;
  logic       ht_auto_p = 1'b0;
  logic       ht_man = 1'b0;
  int         ht_div = 0;
  assign half_tick = ht_auto_p | ht_man;

  int n_checks = 0;
  int n_fail   = 0;

  // monitor state
  logic       mon_clr = 1'b0;
  logic [7:0] miso_pat = 8'h00;
  logic [7:0] mosi_seq = 8'h00;
  logic       sclk_prev = 1'b0;
  logic       rdy_prev = 1'b1;
  logic       cs_hi_seen = 1'b0;
  int rise_cnt = 0, fall_cnt = 0, valid_cnt = 0, ht_since = 0, first_rise_ht = -1;

  t05_spi_byte_engine #(.DATA_W(8), .CS_SETUP_TICKS(1)) dut (
    .clk(clk), .nrst(nrst), .half_tick(half_tick), .start(start),
    .tx_byte(tx_byte), .cs_hold(cs_hold), .cs_release(cs_release), .miso(miso),
`ifdef T05_SPI_LOOPBACK_EN
    .loopback(loopback),
`endif
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .ready(ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ht_auto) begin
      ht_div    = (ht_div == 3) ? 0 : ht_div + 1;
      ht_auto_p = (ht_div == 0);
    end else begin
      ht_div    = 0;
      ht_auto_p = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (mon_clr) begin
      rise_cnt = 0; fall_cnt = 0; valid_cnt = 0; mosi_seq = 8'h00;
      ht_since = 0; first_rise_ht = -1; cs_hi_seen = 1'b0;
      miso = miso_pat[7];
    end else begin
      if (start && rdy_prev && !ready) ht_since = 0;
      else if (half_tick) ht_since++;
      if (sclk && !sclk_prev) begin
        rise_cnt++;
        mosi_seq = {mosi_seq[6:0], mosi};
        if (first_rise_ht < 0) first_rise_ht = ht_since;
        if (rise_cnt < 8) miso = miso_pat[7-rise_cnt];
      end
      if (!sclk && sclk_prev) fall_cnt++;
      if (rx_valid) valid_cnt++;
      if (cs_n) cs_hi_seen = 1'b1;
    end
    sclk_prev = sclk;
    rdy_prev  = ready;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon(input logic [7:0] pat);
    miso_pat = pat;
    mon_clr  = 1'b1;
    @(negedge clk);
    mon_clr  = 1'b0;
  endtask

  // drives start for one clk, then scrambles tx_byte/cs_hold to prove they were latched
  task automatic do_start(input logic [7:0] tx, input logic hold);
    tx_byte = tx;
    cs_hold = hold;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    tx_byte = ~tx;
    cs_hold = ~hold;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!rx_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!rx_valid) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_rises(input string tag, input int cnt);
    int n = 0;
    while (!(rise_cnt == cnt && sclk) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!(rise_cnt == cnt && sclk)) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_sclk", 32'(sclk), 32'd0);
    check_eq("rst_mosi", 32'(mosi), 32'd1);
    check_eq("rst_cs_n", 32'(cs_n), 32'd1);
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_rx_byte", 32'(rx_byte), 32'h00);
    nrst = 1'b1;
    @(negedge clk);

    // basic byte
    ht_auto = 1'b1;
    clear_mon(8'h3C);
    do_start(8'hA5, 1'b0);
    check_eq("basic_busy", 32'(ready), 32'd0);
    wait_valid("basic");
    check_eq("basic_rx", 32'(rx_byte), 32'h3C);
    check_eq("basic_mosi_seq", 32'(mosi_seq), 32'hA5);
    check_eq("basic_rises", 32'(rise_cnt), 32'd8);
    check_eq("basic_first_rise_ht", 32'(first_rise_ht), 32'd2);
    check_eq("basic_cs_n", 32'(cs_n), 32'd1);
    check_eq("basic_mosi_idle", 32'(mosi), 32'd1);
    check_eq("basic_ready", 32'(ready), 32'd1);
    @(negedge clk);
    check_eq("basic_valid_pulse", 32'(rx_valid), 32'd0);
    check_eq("basic_valid_cnt", 32'(valid_cnt), 32'd1);

    // start while busy is ignored
    clear_mon(8'hC9);
    do_start(8'h51, 1'b0);
    wait_rises("ign", 3);
    tx_byte = 8'h00;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_valid("ign");
    check_eq("ign_mosi_seq", 32'(mosi_seq), 32'h51);
    check_eq("ign_rx", 32'(rx_byte), 32'hC9);
    repeat (40) @(negedge clk);
    check_eq("ign_valid_cnt", 32'(valid_cnt), 32'd1);
    check_eq("ign_rises", 32'(rise_cnt), 32'd8);

    // CS hold chain with back-to-back start
    clear_mon(8'h81);
    do_start(8'hFF, 1'b1);
    wait_valid("chain1");
    check_eq("chain1_rx", 32'(rx_byte), 32'h81);
    check_eq("chain1_cs_n", 32'(cs_n), 32'd0);
    miso_pat = 8'h7E;
    mon_clr  = 1'b1;
    tx_byte  = 8'h40;
    cs_hold  = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    mon_clr  = 1'b0;
    start    = 1'b0;
    tx_byte  = 8'hBF;
    cs_hold  = 1'b0;
    wait_valid("chain2");
    check_eq("chain2_rx", 32'(rx_byte), 32'h7E);
    check_eq("chain2_mosi_seq", 32'(mosi_seq), 32'h40);
    check_eq("chain2_no_setup", 32'(first_rise_ht), 32'd1);
    check_eq("chain2_cs_low", 32'(cs_hi_seen), 32'd0);
    check_eq("chain2_cs_n", 32'(cs_n), 32'd0);
    @(negedge clk);
    cs_release = 1'b1;
    @(negedge clk);
    cs_release = 1'b0;
    check_eq("release_cs_n", 32'(cs_n), 32'd1);

    // start coincident with half_tick in IDLE
    ht_auto = 1'b0;
    clear_mon(8'h5A);
    tx_byte = 8'h96;
    cs_hold = 1'b0;
    start   = 1'b1;
    ht_man  = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    ht_man  = 1'b0;
    begin
      int k = 0;
      while (!rx_valid && k < 300) begin
        @(negedge clk);
        k++;
        ht_man = (k % 3 == 0);
      end
      ht_man = 1'b0;
      if (!rx_valid) check_eq("coin_timeout", 32'd0, 32'd1);
    end
    check_eq("coin_first_rise_ht", 32'(first_rise_ht), 32'd2);
    check_eq("coin_rises", 32'(rise_cnt), 32'd8);
    check_eq("coin_falls", 32'(fall_cnt), 32'd8);
    check_eq("coin_rx", 32'(rx_byte), 32'h5A);
    check_eq("coin_mosi_seq", 32'(mosi_seq), 32'h96);

    // reset in HIGH after 3 bits
    ht_auto = 1'b1;
    clear_mon(8'hFF);
    do_start(8'hE7, 1'b0);
    wait_rises("rstmid", 3);
    nrst = 1'b0;
    #1;
    check_eq("rstmid_sclk", 32'(sclk), 32'd0);
    check_eq("rstmid_cs_n", 32'(cs_n), 32'd1);
    check_eq("rstmid_mosi", 32'(mosi), 32'd1);
    check_eq("rstmid_ready", 32'(ready), 32'd1);
    check_eq("rstmid_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rstmid_rx_byte", 32'(rx_byte), 32'h00);
    @(negedge clk);
    nrst = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("rstmid_stays_idle", 32'(ready), 32'd1);
    check_eq("rstmid_no_resume", 32'(rise_cnt), 32'd3);

`ifdef T05_SPI_LOOPBACK_EN
    loopback = 1'b1;
    clear_mon(8'h00);
    do_start(8'hC3, 1'b0);
    wait_valid("loop");
    check_eq("loop_rx", 32'(rx_byte), 32'hC3);
    loopback = 1'b0;
`endif

    ht_auto = 1'b0;
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
